// File: rtl/yarp_imem_responder.sv
// Instruction memory responder: preloadable word storage behind a
// req/ready fetch port with a fixed response latency of LATENCY cycles.
//
// Ports:
//   clk, reset_n                      clock, async active-low reset
//   req_i, addr_i                     fetch request and byte address
//   ready_o                           request can be accepted this cycle
//   rvalid_o, rd_data_o, err_o        single-cycle response, data, error flag
//   load_en_i, load_addr_i, load_data_i  preload write port
module yarp_imem_responder #(
    parameter int unsigned DEPTH_WORDS = 1024,
    parameter int unsigned LATENCY     = 1
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        req_i,
    input  logic [31:0] addr_i,
    output logic        ready_o,
    output logic        rvalid_o,
    output logic [31:0] rd_data_o,
    output logic        err_o,
    input  logic        load_en_i,
    input  logic [31:0] load_addr_i,
    input  logic [31:0] load_data_i
);

    localparam int unsigned AW       = $clog2(DEPTH_WORDS);
    localparam logic [31:0] LIMIT    = 32'(DEPTH_WORDS * 4);
    localparam bit          SINGLE   = (LATENCY == 1);
    // WAIT lasts LATENCY-1 edges; the counter hits zero on the last one.
    localparam logic [3:0]  CNT_INIT = (LATENCY > 1) ? 4'(LATENCY - 2) : 4'd0;

    typedef enum logic [1:0] {
        S_IDLE,
        S_WAIT,
        S_RESP
    } state_t;

    state_t      state;
    logic [3:0]  cnt;
    logic [31:0] addr_q;

    logic [31:0] mem [DEPTH_WORDS];

    logic          accept;
    logic          enter_resp;
    logic [31:0]   rd_addr;
    logic [AW-1:0] rd_idx;
    logic          rd_err;
    logic [AW-1:0] ld_idx;
    logic          ld_ok;

    assign ready_o = (state != S_WAIT);
    assign accept  = req_i && ready_o;

    // With LATENCY=1 the read happens on the acceptance edge itself,
    // so the live address is used; otherwise the captured one.
    assign enter_resp = (state == S_WAIT) ? (cnt == 4'd0)
                                          : (accept && SINGLE);
    assign rd_addr = (state == S_WAIT) ? addr_q : addr_i;
    assign rd_idx  = rd_addr[AW+1:2];
    assign rd_err  = (rd_addr[1:0] != 2'b00) || (rd_addr >= LIMIT);

    assign ld_idx = load_addr_i[AW+1:2];
    assign ld_ok  = load_en_i
                 && (load_addr_i[1:0] == 2'b00)
                 && (load_addr_i < LIMIT);

    // Storage is never reset; a same-edge read sees the old word.
    always_ff @(posedge clk) begin
        if (ld_ok) begin
            mem[ld_idx] <= load_data_i;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state     <= S_IDLE;
            cnt       <= 4'd0;
            addr_q    <= 32'h0;
            rvalid_o  <= 1'b0;
            err_o     <= 1'b0;
            rd_data_o <= 32'h0;
        end else begin
            rvalid_o <= enter_resp;
            err_o    <= enter_resp && rd_err;
            if (enter_resp) begin
                rd_data_o <= rd_err ? 32'h0 : mem[rd_idx];
            end
            case (state)
                S_IDLE, S_RESP: begin
                    if (accept) begin
                        addr_q <= addr_i;
                        cnt    <= CNT_INIT;
                        state  <= SINGLE ? S_RESP : S_WAIT;
                    end else begin
                        state <= S_IDLE;
                    end
                end
                S_WAIT: begin
                    if (cnt == 4'd0) begin
                        state <= S_RESP;
                    end else begin
                        cnt <= cnt - 4'd1;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_yarp_imem_responder.sv
// Directed and randomized checks of yarp_imem_responder at LATENCY 1 and 3.
// Two instances share clock, reset and the preload port.
module tb_yarp_imem_responder;

    localparam int DW   = 16;
    localparam int LAT3 = 3;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        ld_en = 1'b0;
    logic [31:0] ld_addr = 32'h0;
    logic [31:0] ld_data = 32'h0;

    logic        req1 = 1'b0;
    logic [31:0] addr1 = 32'h0;
    logic        ready1, rv1, err1;
    logic [31:0] data1;

    logic        req3 = 1'b0;
    logic [31:0] addr3 = 32'h0;
    logic        ready3, rv3, err3;
    logic [31:0] data3;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    yarp_imem_responder #(.DEPTH_WORDS(DW), .LATENCY(1)) u1 (
        .clk(clk), .reset_n(reset_n),
        .req_i(req1), .addr_i(addr1), .ready_o(ready1),
        .rvalid_o(rv1), .rd_data_o(data1), .err_o(err1),
        .load_en_i(ld_en), .load_addr_i(ld_addr), .load_data_i(ld_data)
    );

    yarp_imem_responder #(.DEPTH_WORDS(DW), .LATENCY(LAT3)) u3 (
        .clk(clk), .reset_n(reset_n),
        .req_i(req3), .addr_i(addr3), .ready_o(ready3),
        .rvalid_o(rv3), .rd_data_o(data3), .err_o(err3),
        .load_en_i(ld_en), .load_addr_i(ld_addr), .load_data_i(ld_data)
    );

    typedef struct {
        logic        req;
        logic [31:0] addr;
        logic        le;
        logic [31:0] la;
        logic [31:0] ld;
        logic        rv;
        logic        err;
        logic [31:0] data;
    } vec_t;

    vec_t tbl [16];

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [31:0] pick_addr();
        int k;
        k = int'($urandom_range(0, 9));
        if (k <= 6) return 32'($urandom_range(0, DW - 1)) << 2;
        if (k == 7) return (32'($urandom_range(0, DW - 1)) << 2) | 32'd2;
        if (k == 8) return 32'(DW * 4) + (32'($urandom_range(0, 3)) << 2);
        return 32'hFFFF_FFFC;
    endfunction

    logic [31:0] rmem [DW];
    logic        pend;
    int          left;
    logic [31:0] paddr;
    logic [31:0] lastd;
    logic        mready, acc, erv, eerr;
    logic [31:0] edata;

    initial begin
        // req, addr, load_en, load_addr, load_data, rvalid, err, data
        tbl[0]  = '{1'b0, 32'h00, 1'b1, 32'h00, 32'h0000_0013, 1'b0, 1'b0, 32'h0};
        tbl[1]  = '{1'b0, 32'h00, 1'b1, 32'h04, 32'h0010_0093, 1'b0, 1'b0, 32'h0};
        tbl[2]  = '{1'b1, 32'h00, 1'b0, 32'h00, 32'h0, 1'b1, 1'b0, 32'h0000_0013};
        tbl[3]  = '{1'b1, 32'h04, 1'b0, 32'h00, 32'h0, 1'b1, 1'b0, 32'h0010_0093};
        tbl[4]  = '{1'b0, 32'h00, 1'b0, 32'h00, 32'h0, 1'b0, 1'b0, 32'h0010_0093};
        tbl[5]  = '{1'b1, 32'h02, 1'b0, 32'h00, 32'h0, 1'b1, 1'b1, 32'h0};
        tbl[6]  = '{1'b1, 32'h40, 1'b0, 32'h00, 32'h0, 1'b1, 1'b1, 32'h0};
        tbl[7]  = '{1'b0, 32'h00, 1'b1, 32'h3C, 32'hCAFE_F00D, 1'b0, 1'b0, 32'h0};
        tbl[8]  = '{1'b1, 32'h3C, 1'b0, 32'h00, 32'h0, 1'b1, 1'b0, 32'hCAFE_F00D};
        tbl[9]  = '{1'b1, 32'h04, 1'b1, 32'h04, 32'hDEAD_BEEF, 1'b1, 1'b0, 32'h0010_0093};
        tbl[10] = '{1'b1, 32'h04, 1'b0, 32'h00, 32'h0, 1'b1, 1'b0, 32'hDEAD_BEEF};
        tbl[11] = '{1'b1, 32'h04, 1'b1, 32'h06, 32'h1111_1111, 1'b1, 1'b0, 32'hDEAD_BEEF};
        tbl[12] = '{1'b1, 32'h04, 1'b0, 32'h00, 32'h0, 1'b1, 1'b0, 32'hDEAD_BEEF};
        tbl[13] = '{1'b0, 32'h00, 1'b1, 32'h44, 32'h2222_2222, 1'b0, 1'b0, 32'hDEAD_BEEF};
        tbl[14] = '{1'b1, 32'h04, 1'b0, 32'h00, 32'h0, 1'b1, 1'b0, 32'hDEAD_BEEF};
        tbl[15] = '{1'b1, 32'h00, 1'b0, 32'h00, 32'h0, 1'b1, 1'b0, 32'h0000_0013};

        // Reset state.
        step();
        step();
        chk("rst_rv1", 32'(rv1), 32'd0);
        chk("rst_err1", 32'(err1), 32'd0);
        chk("rst_data1", data1, 32'h0);
        chk("rst_ready1", 32'(ready1), 32'd1);
        chk("rst_rv3", 32'(rv3), 32'd0);
        chk("rst_err3", 32'(err3), 32'd0);
        chk("rst_data3", data3, 32'h0);
        chk("rst_ready3", 32'(ready3), 32'd1);
        reset_n = 1'b1;

        // LATENCY=1 table: outputs after each edge reflect that edge's request.
        foreach (tbl[i]) begin
            req1    = tbl[i].req;
            addr1   = tbl[i].addr;
            ld_en   = tbl[i].le;
            ld_addr = tbl[i].la;
            ld_data = tbl[i].ld;
            step();
            chk($sformatf("t%0d_rv", i), 32'(rv1), 32'(tbl[i].rv));
            chk($sformatf("t%0d_err", i), 32'(err1), 32'(tbl[i].err));
            chk($sformatf("t%0d_data", i), data1, tbl[i].data);
            chk($sformatf("t%0d_ready", i), 32'(ready1), 32'd1);
        end
        req1  = 1'b0;
        ld_en = 1'b0;

        // u3 saw the same loads; restore word 1.
        ld_en   = 1'b1;
        ld_addr = 32'h4;
        ld_data = 32'h0010_0093;
        step();
        ld_en = 1'b0;

        // LATENCY=3 timing.
        req3  = 1'b1;
        addr3 = 32'h4;
        step();
        req3 = 1'b0;
        chk("l3_e0_ready", 32'(ready3), 32'd0);
        chk("l3_e0_rv", 32'(rv3), 32'd0);
        step();
        chk("l3_e1_ready", 32'(ready3), 32'd0);
        chk("l3_e1_rv", 32'(rv3), 32'd0);
        step();
        chk("l3_e2_rv", 32'(rv3), 32'd1);
        chk("l3_e2_err", 32'(err3), 32'd0);
        chk("l3_e2_data", data3, 32'h0010_0093);
        chk("l3_e2_ready", 32'(ready3), 32'd1);
        step();
        chk("l3_e3_rv", 32'(rv3), 32'd0);
        chk("l3_e3_data", data3, 32'h0010_0093);
        chk("l3_e3_ready", 32'(ready3), 32'd1);

        // LATENCY=3 misaligned.
        req3  = 1'b1;
        addr3 = 32'h2;
        step();
        req3 = 1'b0;
        step();
        step();
        chk("l3_mis_rv", 32'(rv3), 32'd1);
        chk("l3_mis_err", 32'(err3), 32'd1);
        chk("l3_mis_data", data3, 32'h0);
        step();
        chk("l3_mis_err_after", 32'(err3), 32'd0);

        // Reset in WAIT discards the request; storage survives.
        req3  = 1'b1;
        addr3 = 32'h4;
        step();
        req3 = 1'b0;
        chk("rw_ready_wait", 32'(ready3), 32'd0);
        reset_n = 1'b0;
        #1;
        chk("rw_rv", 32'(rv3), 32'd0);
        chk("rw_err", 32'(err3), 32'd0);
        chk("rw_data", data3, 32'h0);
        chk("rw_ready", 32'(ready3), 32'd1);
        step();
        step();
        chk("rw_rv_held", 32'(rv3), 32'd0);
        req3    = 1'b1;
        addr3   = 32'h0;
        reset_n = 1'b1;
        step();
        req3 = 1'b0;
        chk("rw_first_acc", 32'(ready3), 32'd0);
        chk("rw_no_stale0", 32'(rv3), 32'd0);
        step();
        chk("rw_no_stale1", 32'(rv3), 32'd0);
        step();
        chk("rw_ret_rv", 32'(rv3), 32'd1);
        chk("rw_ret_data", data3, 32'h0000_0013);
        lastd = 32'h0000_0013;

        // Random traffic on LATENCY=3 against a reference memory.
        for (int w = 0; w < DW; w++) begin
            ld_en   = 1'b1;
            ld_addr = 32'(w) << 2;
            ld_data = $urandom;
            rmem[w] = ld_data;
            step();
        end
        ld_en = 1'b0;
        pend  = 1'b0;
        left  = 0;
        paddr = 32'h0;
        for (int i = 0; i < 300; i++) begin
            req3    = ($urandom_range(0, 2) != 0);
            addr3   = pick_addr();
            ld_en   = ($urandom_range(0, 2) == 0);
            ld_addr = pick_addr();
            ld_data = $urandom;
            mready  = !pend;
            chk("rnd_ready", 32'(ready3), 32'(mready));
            acc = req3 && mready;
            step();
            erv   = 1'b0;
            eerr  = 1'b0;
            edata = lastd;
            if (pend) begin
                left--;
                if (left == 0) begin
                    pend  = 1'b0;
                    erv   = 1'b1;
                    eerr  = (paddr[1:0] != 2'b00) || (paddr >= 32'(DW * 4));
                    edata = eerr ? 32'h0 : rmem[paddr[5:2]];
                    lastd = edata;
                end
            end
            if (acc) begin
                pend  = 1'b1;
                left  = LAT3 - 1;
                paddr = addr3;
            end
            if (ld_en && ld_addr[1:0] == 2'b00 && ld_addr < 32'(DW * 4))
                rmem[ld_addr[5:2]] = ld_data;
            chk("rnd_rv", 32'(rv3), 32'(erv));
            chk("rnd_err", 32'(err3), 32'(eerr));
            chk("rnd_data", data3, edata);
        end
        req3  = 1'b0;
        ld_en = 1'b0;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
